// File: rtl/four_bit_multiplier_if.sv
// ---------------------------------------------------------------------------
// four_bit_multiplier_if
//
// Bundles the operand/handshake/result signals of the shift-and-add
// multiplier so the requester and the multiplier share one connection.
//
// Signals:
//   A        multiplicand from the A operand register (WIDTH bits)
//   B        multiplier from the B operand register (WIDTH bits)
//   start    level-sampled request for a new multiplication
//   product  result register (2*WIDTH bits), held until the next completion
//   busy     high while a multiplication is in progress
//   done     one-cycle pulse marking a freshly loaded product
//
// Modports:
//   master   the requester: drives A, B, start; observes the results
//   slave    the multiplier: observes A, B, start; drives the results
// ---------------------------------------------------------------------------
interface four_bit_multiplier_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0]   A;
    logic [WIDTH-1:0]   B;
    logic               start;
    logic [2*WIDTH-1:0] product;
    logic               busy;
    logic               done;

    modport master (
        output A,
        output B,
        output start,
        input  product,
        input  busy,
        input  done
    );

    modport slave (
        input  A,
        input  B,
        input  start,
        output product,
        output busy,
        output done
    );
endinterface

// File: rtl/four_bit_multiplier.sv
// ---------------------------------------------------------------------------
// four_bit_multiplier
//
// Sequential unsigned shift-and-add multiplier. Operands are captured once
// when a start request is seen in IDLE; one partial product is accumulated
// per clock, and after WIDTH steps the result is loaded into the product
// register, which then holds until the next completed operation.
//
// Ports:
//   clk    system clock, all state updates on the rising edge
//   rst_n  synchronous active-low reset
//   bus    slave side of four_bit_multiplier_if
//          (A, B, start in; product, busy, done out)
// ---------------------------------------------------------------------------
module four_bit_multiplier #(
    parameter int WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    four_bit_multiplier_if.slave  bus
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;

    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_sum;
    logic [WIDTH-1:0]   mplier;
    logic [CNT_W-1:0]   cnt;
    logic               last_step;

    // State register: reset wins over everything, including a pending start.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: start only matters in IDLE, so a request seen during
    // RUN or DONE is dropped rather than queued.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = RUN;
            RUN:     if (last_step) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The accumulator value after this step's conditional add. The final
    // product is taken from here so the last partial product is included on
    // the same edge that leaves RUN.
    always_comb begin
        acc_sum   = acc + (mplier[0] ? mcand : '0);
        last_step = (cnt == CNT_W'(WIDTH - 1));
    end

    // Datapath: operands are copied into private registers on the start edge
    // so later changes on A/B cannot disturb an operation in flight. The
    // product register is written only on the final RUN step or by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mcand       <= '0;
            mplier      <= '0;
            acc         <= '0;
            cnt         <= '0;
            bus.product <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        mcand  <= {{WIDTH{1'b0}}, bus.A};
                        mplier <= bus.B;
                        acc    <= '0;
                        cnt    <= '0;
                    end
                end
                RUN: begin
                    acc    <= acc_sum;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CNT_W'(1);
                    if (last_step) begin
                        bus.product <= acc_sum;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Status outputs come straight from the registered state, so they cannot
    // glitch with start.
    always_comb begin
        bus.busy = (state == RUN);
        bus.done = (state == DONE);
    end

endmodule
